button_debounce_pulse: RTL and testbench
========================================

// Module: button_debounce_pulse
// PURPOSE
//  Front-end conditioner for the push-button that advances the LED counter.
//  Synchronises the raw button, debounces it with a stability timer, and emits
//  single-cycle press/release strobes plus optional hold-to-repeat steps.
//  step_pulse drives the counter's count-enable; one pulse = one count step.
// PARAMETERS
//  DEBOUNCE_CYCLES      1_000_000   cycles input must be stable to accept an edge (>=2)
//  REPEAT_EN            1           1 = auto-repeat while held, 0 = press only
//  REPEAT_DELAY_CYCLES  50_000_000  press_pulse to first repeat step (>=2)
//  REPEAT_RATE_CYCLES   25_000_000  spacing of subsequent repeat steps (>=2)
// PORTS
//  clk            in   1  system clock, all logic on posedge
//  rst_n          in   1  synchronous, active-HIGH reset (name kept; polarity is high)
//  button         in   1  raw asynchronous push-button, 1 = pressed
//  debounced      out  1  registered debounced level
//  press_pulse    out  1  one-cycle strobe on accepted press
//  release_pulse  out  1  one-cycle strobe on accepted release
//  step_pulse     out  1  press_pulse OR repeat strobe; feeds counter enable
// BEHAVIOUR
//  - Reset: all outputs 0, sync flops 0, FSM IDLE, all timers 0. Reset mid-hold
//    aborts silently: no release_pulse. A button still held after reset is
//    treated as a new press and must pass the full debounce time.
//  - Sync: 2-FF synchroniser. sb = second stage. The FSM only sees sb.
//  - FSM: IDLE (stable 0) -> PRESS_WAIT when sb=1, with db_cnt=0.
//    PRESS_WAIT: when sb=1, db_cnt++. When db_cnt==DEBOUNCE_CYCLES-1 and sb=1,
//    go to HELD. When sb=0, return to IDLE and clear db_cnt.
//    HELD: when sb=0, go to RELEASE_WAIT with db_cnt=0.
//    RELEASE_WAIT: symmetric to PRESS_WAIT; on timeout go to IDLE. When sb=1,
//    return to HELD.
//  - Latency: edge 0 is the first posedge sampling button=1. debounced rises and
//    press_pulse/step_pulse are high in the cycle after edge DEBOUNCE_CYCLES+2.
//    Release uses the same count for debounced fall and release_pulse.
//  - Repeat (REPEAT_EN=1): rp_cnt clears on HELD entry and counts in HELD.
//    The first repeat step comes REPEAT_DELAY_CYCLES after press_pulse.
//    Later steps come every REPEAT_RATE_CYCLES. rp_cnt freezes in RELEASE_WAIT
//    and no steps are issued there. rp_cnt resumes if HELD is re-entered.
//    rp_cnt saturates safely and never wraps into a spurious pulse.
//  - Strobes are exactly 1 cycle. press_pulse and release_pulse are never high
//    together. step_pulse is never high in IDLE, PRESS_WAIT or RELEASE_WAIT.
//  - Widths: db_cnt is $clog2(DEBOUNCE_CYCLES)+1 bits. rp_cnt is
//    $clog2(max(REPEAT_DELAY_CYCLES,REPEAT_RATE_CYCLES))+1 bits. Counters are
//    unsigned, compare for equality only, and never overflow.
//  - All outputs are registered. There is no combinational path from button to
//    any output.
// STRUCTURE
//  - debounce_defs.vh: FSM state localparams (IDLE, PRESS_WAIT, HELD,
//    RELEASE_WAIT; 2-bit binary). Shared with the bench for state checks.
//  - One sub-module, sync_2ff (clk, rst_n, d, q). It is reusable for other
//    board inputs.
//  - Top holds the FSM, db_cnt, rp_cnt and output registers.
// TESTING  (bench params: DEBOUNCE=4, REPEAT_DELAY=20, REPEAT_RATE=8)
//  1 Clean press: button 0->1, held 15 cycles, REPEAT_EN=0 -> one press_pulse
//    and step_pulse in the cycle after edge 6. debounced=1 from there on.
//  2 Bounce: button 1 for 3 cycles, 0 for 1, then 1 stable -> no pulse for the
//    glitch. Exactly one press_pulse 6 edges after the final rise.
//  3 Repeat: hold 60 cycles after press -> step_pulse at press+20, +28, +36,
//    +44, +52. press_pulse occurs once.
//  4 Release: drop button after test 3 -> release_pulse and debounced=0 after
//    edge 6 of release. No step_pulse during RELEASE_WAIT. A 2-cycle low glitch
//    while held gives no release_pulse.
//  5 Reset mid-hold: rst_n=1 for 1 cycle in HELD -> all outputs 0 next cycle,
//    no release_pulse. With button still 1, a fresh press_pulse comes 6 edges
//    after reset deasserts.
//  6 REPEAT_EN=0: hold 100 cycles -> exactly one step_pulse. debounced stays 1.

Source files
------------

// File: rtl/button_debounce_pulse_pkg.sv
// Shared definitions for the push-button conditioner: FSM state encoding and
// a small helper used to size the repeat timer.
package button_debounce_pulse_pkg;

  // Debounce FSM states, 2-bit binary encoding.
  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_HELD         = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } db_state_e;

  // Larger of two unsigned values; used for elaboration-time width sizing.
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    if (a > b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

endpackage

// File: rtl/button_debounce_pulse_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous board input.
// Reusable for any slow external signal; reset clears both stages.
module button_debounce_pulse_sync_2ff (
  input  logic clk,
  input  logic rst_n,  // synchronous, active-high despite the name
  input  logic d,
  output logic q
);

  logic s1_q;
  logic s2_q;

  // Two-stage capture of the raw input into the clk domain
  always_ff @(posedge clk) begin
    if (rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/button_debounce_pulse.sv
// Push-button conditioner: synchronises the raw button, debounces it with a
// stability timer and produces press/release strobes plus hold-to-repeat
// steps. step_pulse is the count-enable for the LED counter.
module button_debounce_pulse
  import button_debounce_pulse_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES     = 1_000_000,
  parameter bit          REPEAT_EN           = 1'b1,
  parameter int unsigned REPEAT_DELAY_CYCLES = 50_000_000,
  parameter int unsigned REPEAT_RATE_CYCLES  = 25_000_000
) (
  input  logic clk,
  input  logic rst_n,          // synchronous, active-high despite the name
  input  logic button,         // raw, asynchronous, 1 = pressed
  output logic debounced,
  output logic press_pulse,
  output logic release_pulse,
  output logic step_pulse
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int RP_W = $clog2(max_u(REPEAT_DELAY_CYCLES, REPEAT_RATE_CYCLES)) + 1;

  localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_ONE     = DB_W'(1);
  localparam logic [DB_W-1:0] DB_ZERO    = {DB_W{1'b0}};
  localparam logic [RP_W-1:0] RP_DLY_END = RP_W'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [RP_W-1:0] RP_RAT_END = RP_W'(REPEAT_RATE_CYCLES - 1);
  localparam logic [RP_W-1:0] RP_ONE     = RP_W'(1);
  localparam logic [RP_W-1:0] RP_ZERO    = {RP_W{1'b0}};
  localparam logic [RP_W-1:0] RP_MAX     = {RP_W{1'b1}};

  logic            sb_s;
  logic [RP_W-1:0] rp_target_s;

  db_state_e       state_q,     state_d;
  logic [DB_W-1:0] db_cnt_q,    db_cnt_d;
  logic [RP_W-1:0] rp_cnt_q,    rp_cnt_d;
  logic            rp_first_q,  rp_first_d;   // next repeat uses the initial delay
  logic            debounced_q, debounced_d;
  logic            press_q,     press_d;
  logic            release_q,   release_d;
  logic            step_q,      step_d;

  button_debounce_pulse_sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (button),
    .q     (sb_s)
  );

  // Repeat timer end point: long delay before the first step, then the rate
  always_comb begin
    rp_target_s = RP_RAT_END;
    if (rp_first_q) begin
      rp_target_s = RP_DLY_END;
    end else begin
      rp_target_s = RP_RAT_END;
    end
  end

  // Next-state, counter and strobe logic of the debounce FSM
  always_comb begin
    state_d     = state_q;
    db_cnt_d    = db_cnt_q;
    rp_cnt_d    = rp_cnt_q;
    rp_first_d  = rp_first_q;
    debounced_d = debounced_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    step_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        db_cnt_d    = DB_ZERO;
        debounced_d = 1'b0;
        if (sb_s) begin
          state_d = ST_PRESS_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_PRESS_WAIT: begin
        if (!sb_s) begin
          state_d  = ST_IDLE;
          db_cnt_d = DB_ZERO;
        end else if (db_cnt_q == DB_LAST) begin
          // Accepted press: fresh repeat sequence starts here
          state_d     = ST_HELD;
          db_cnt_d    = DB_ZERO;
          rp_cnt_d    = RP_ZERO;
          rp_first_d  = 1'b1;
          debounced_d = 1'b1;
          press_d     = 1'b1;
          step_d      = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + DB_ONE;
        end
      end

      ST_HELD: begin
        if (!sb_s) begin
          state_d  = ST_RELEASE_WAIT;
          db_cnt_d = DB_ZERO;
        end else if (REPEAT_EN) begin
          if (rp_cnt_q == rp_target_s) begin
            step_d     = 1'b1;
            rp_cnt_d   = RP_ZERO;
            rp_first_d = 1'b0;
          end else if (rp_cnt_q != RP_MAX) begin
            rp_cnt_d = rp_cnt_q + RP_ONE;
          end else begin
            rp_cnt_d = rp_cnt_q;   // saturate; never wrap into a false match
          end
        end else begin
          rp_cnt_d = rp_cnt_q;
        end
      end

      ST_RELEASE_WAIT: begin
        // rp_cnt is left untouched here so a bounce resumes the repeat timing
        if (sb_s) begin
          state_d  = ST_HELD;
          db_cnt_d = DB_ZERO;
        end else if (db_cnt_q == DB_LAST) begin
          state_d     = ST_IDLE;
          db_cnt_d    = DB_ZERO;
          debounced_d = 1'b0;
          release_d   = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + DB_ONE;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        db_cnt_d    = DB_ZERO;
        rp_cnt_d    = RP_ZERO;
        rp_first_d  = 1'b1;
        debounced_d = 1'b0;
      end
    endcase
  end

  // State, counters and registered outputs; reset aborts any hold silently
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q     <= ST_IDLE;
      db_cnt_q    <= DB_ZERO;
      rp_cnt_q    <= RP_ZERO;
      rp_first_q  <= 1'b1;
      debounced_q <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      step_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      db_cnt_q    <= db_cnt_d;
      rp_cnt_q    <= rp_cnt_d;
      rp_first_q  <= rp_first_d;
      debounced_q <= debounced_d;
      press_q     <= press_d;
      release_q   <= release_d;
      step_q      <= step_d;
    end
  end

  assign debounced     = debounced_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign step_pulse    = step_q;

endmodule

// File: tb/tb_button_debounce_pulse.sv
// Directed bench for button_debounce_pulse with DEBOUNCE=4, REPEAT_DELAY=20,
// REPEAT_RATE=8. dut0 has repeat disabled, dut1 has it enabled; both share
// clock, reset and button. Edge k is the k-th posedge after button changes;
// outputs are observed 1 time unit after each posedge.
module tb_button_debounce_pulse;

  logic clk;
  logic rst_n;
  logic button;
  logic deb0, press0, rel0, step0;
  logic deb1, press1, rel1, step1;

  int checks;
  int errors;

  button_debounce_pulse #(
    .DEBOUNCE_CYCLES(4), .REPEAT_EN(1'b0),
    .REPEAT_DELAY_CYCLES(20), .REPEAT_RATE_CYCLES(8)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .button(button),
    .debounced(deb0), .press_pulse(press0),
    .release_pulse(rel0), .step_pulse(step0)
  );

  button_debounce_pulse #(
    .DEBOUNCE_CYCLES(4), .REPEAT_EN(1'b1),
    .REPEAT_DELAY_CYCLES(20), .REPEAT_RATE_CYCLES(8)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .button(button),
    .debounced(deb1), .press_pulse(press1),
    .release_pulse(rel1), .step_pulse(step1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reset both DUTs with the button released, then leave them idle briefly
  task automatic do_reset();
    rst_n  = 1'b1;
    button = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n  = 1'b1;
    button = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({deb0, press0, rel0, step0} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_dut0 got %b exp 0000", {deb0, press0, rel0, step0});
    end
    checks++;
    if ({deb1, press1, rel1, step1} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_dut1 got %b exp 0000", {deb1, press1, rel1, step1});
    end
  endtask

  task automatic test_clean_press();
    int n_press;
    int n_step;
    int first_k;
    n_press = 0; n_step = 0; first_k = -1;
    do_reset();
    button = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk);
      #1;
      if (press0) begin
        n_press++;
        if (first_k < 0) first_k = k;
      end
      if (step0) n_step++;
      checks++;
      if (deb0 !== (k >= 6)) begin
        errors++;
        $display("FAIL clean_debounced k=%0d got %b exp %b", k, deb0, (k >= 6));
      end
    end
    checks++;
    if (n_press !== 1) begin errors++; $display("FAIL clean_press_count got %0d exp 1", n_press); end
    checks++;
    if (first_k !== 6) begin errors++; $display("FAIL clean_press_edge got %0d exp 6", first_k); end
    checks++;
    if (n_step !== 1) begin errors++; $display("FAIL clean_step_count got %0d exp 1", n_step); end
  endtask

  task automatic test_bounce();
    // 1,1,1,0 then stable 1: the final rise is edge 4, press expected at edge 10
    do_reset();
    for (int j = 0; j < 20; j++) begin
      button = (j != 3);
      @(posedge clk);
      #1;
      checks++;
      if (press1 !== (j == 10)) begin
        errors++;
        $display("FAIL bounce_press j=%0d got %b exp %b", j, press1, (j == 10));
      end
      checks++;
      if (deb1 !== (j >= 10)) begin
        errors++;
        $display("FAIL bounce_debounced j=%0d got %b exp %b", j, deb1, (j >= 10));
      end
    end
  endtask

  task automatic test_repeat_release();
    logic exp_step;
    int   n_press;
    n_press = 0;
    do_reset();
    button = 1'b1;
    for (int k = 0; k < 62; k++) begin
      @(posedge clk);
      #1;
      exp_step = (k == 6) || ((k >= 26) && (((k - 26) % 8) == 0));
      if (press1) n_press++;
      checks++;
      if (step1 !== exp_step) begin
        errors++;
        $display("FAIL repeat_step k=%0d got %b exp %b", k, step1, exp_step);
      end
    end
    checks++;
    if (n_press !== 1) begin errors++; $display("FAIL repeat_press_count got %0d exp 1", n_press); end
    // Release: step at edge 66 would have fallen in RELEASE_WAIT and must not appear
    button = 1'b0;
    for (int j = 0; j < 10; j++) begin
      @(posedge clk);
      #1;
      checks++;
      if (rel1 !== (j == 6)) begin
        errors++;
        $display("FAIL release_pulse j=%0d got %b exp %b", j, rel1, (j == 6));
      end
      checks++;
      if (deb1 !== (j < 6)) begin
        errors++;
        $display("FAIL release_debounced j=%0d got %b exp %b", j, deb1, (j < 6));
      end
      checks++;
      if (step1 !== 1'b0) begin
        errors++;
        $display("FAIL release_no_step j=%0d got %b exp 0", j, step1);
      end
    end
  endtask

  task automatic test_hold_glitch();
    do_reset();
    for (int k = 0; k < 21; k++) begin
      button = !((k == 8) || (k == 9));
      @(posedge clk);
      #1;
      checks++;
      if (rel1 !== 1'b0) begin
        errors++;
        $display("FAIL glitch_release k=%0d got %b exp 0", k, rel1);
      end
      checks++;
      if (deb1 !== (k >= 6)) begin
        errors++;
        $display("FAIL glitch_debounced k=%0d got %b exp %b", k, deb1, (k >= 6));
      end
      checks++;
      if (step1 !== (k == 6)) begin
        errors++;
        $display("FAIL glitch_step k=%0d got %b exp %b", k, step1, (k == 6));
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    int n_press;
    n_press = 0;
    do_reset();
    button = 1'b1;
    for (int k = 0; k < 11; k++) begin
      @(posedge clk);
      #1;
      if (press1) n_press++;
    end
    checks++;
    if (n_press !== 1) begin errors++; $display("FAIL midreset_first_press got %0d exp 1", n_press); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    checks++;
    if ({deb1, press1, rel1, step1} !== 4'b0000) begin
      errors++;
      $display("FAIL midreset_outputs got %b exp 0000", {deb1, press1, rel1, step1});
    end
    for (int j = 0; j < 10; j++) begin
      @(posedge clk);
      #1;
      checks++;
      if (press1 !== (j == 6)) begin
        errors++;
        $display("FAIL midreset_repress j=%0d got %b exp %b", j, press1, (j == 6));
      end
      checks++;
      if (rel1 !== 1'b0) begin
        errors++;
        $display("FAIL midreset_no_release j=%0d got %b exp 0", j, rel1);
      end
      checks++;
      if (deb1 !== (j >= 6)) begin
        errors++;
        $display("FAIL midreset_debounced j=%0d got %b exp %b", j, deb1, (j >= 6));
      end
    end
  endtask

  task automatic test_no_repeat();
    int n_step;
    int n_press;
    int n_deb_low;
    n_step = 0; n_press = 0; n_deb_low = 0;
    do_reset();
    button = 1'b1;
    for (int k = 0; k < 106; k++) begin
      @(posedge clk);
      #1;
      if (step0) n_step++;
      if (press0) n_press++;
      if ((k >= 6) && (deb0 !== 1'b1)) n_deb_low++;
    end
    checks++;
    if (n_step !== 1) begin errors++; $display("FAIL norepeat_step_count got %0d exp 1", n_step); end
    checks++;
    if (n_press !== 1) begin errors++; $display("FAIL norepeat_press_count got %0d exp 1", n_press); end
    checks++;
    if (n_deb_low !== 0) begin errors++; $display("FAIL norepeat_debounced_drops got %0d exp 0", n_deb_low); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b1;
    button = 1'b0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_repeat_release();
    test_hold_glitch();
    test_reset_mid_hold();
    test_no_repeat();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Guard against a stuck simulation
  initial begin
    #1000000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule
